traffic_phase_sequencer: RTL

// Time base and phase sequencer for the two-road traffic light. Divides the system clock

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/traffic_phase_sequencer_pwm_gen.sv | 46 ++++
 rtl/traffic_phase_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared phase encoding and the time-to-phase band decoder for the traffic sequencer.
package traffic_pkg;

  localparam logic [2:0] PH_A_GREEN  = 3'd0;
  localparam logic [2:0] PH_A_YELLOW = 3'd1;
  localparam logic [2:0] PH_A_ALLRED = 3'd2;
  localparam logic [2:0] PH_B_GREEN  = 3'd3;
  localparam logic [2:0] PH_B_YELLOW = 3'd4;
  localparam logic [2:0] PH_B_ALLRED = 3'd5;

  // Map a cycle position to its phase; road B occupies the second half of the cycle.
  function automatic logic [2:0] band(input int t, input int g, input int y, input int r);
    int half;
    half = g + y + r;
    if (t < g)                 return PH_A_GREEN;
    else if (t < g + y)        return PH_A_YELLOW;
    else if (t < half)         return PH_A_ALLRED;
    else if (t < half + g)     return PH_B_GREEN;
    else if (t < half + g + y) return PH_B_YELLOW;
    else                       return PH_B_ALLRED;
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer_pwm_gen.sv
// PWM dim strobe generator: clock divider, 3-bit step counter, registered duty compares.
module pwm_gen #(
  parameter int PWM_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic pwm_12p5,
  output logic pwm_25
);

  localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          step;
  logic          p12_q, p12_d;
  logic          p25_q, p25_d;

  // Divider wrap advances the counter; duty outputs are compared from the current count.
  always_comb begin
    step  = (div_q == DW'(PWM_DIV - 1));
    div_d = step ? '0 : div_q + DW'(1);
    cnt_d = step ? cnt_q + 3'd1 : cnt_q;
    p25_d = (cnt_q < 3'd2);
    p12_d = (cnt_q == 3'd0);
  end

  // State and registered outputs, cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
      p12_q <= 1'b0;
      p25_q <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      p12_q <= p12_d;
      p25_q <= p25_d;
    end
  end

  assign pwm_12p5 = p12_q;
  assign pwm_25   = p25_q;

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Two-road traffic light time base: tick prescaler, cycle position timer with pedestrian
// green cuts and acknowledges, plus PWM dim strobes.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 10,
  parameter int G_T     = 40,
  parameter int Y_T     = 8,
  parameter int R_T     = 2,
  parameter int MIN_G_T = 10,
  parameter int PWM_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  input  logic       hold,
  output logic [6:0] phase_time,
  output logic [2:0] phase,
  output logic       tick,
  output logic       ped_ack_a,
  output logic       ped_ack_b,
  output logic       pwm_12p5,
  output logic       pwm_25
);

  localparam int TICKS = CLK_HZ / TICK_HZ;
  localparam int PRE_W = $clog2(TICKS);
  localparam int HALF  = G_T + Y_T + R_T;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             tick_ev;
  logic [6:0]       time_q, time_d;
  logic [2:0]       phase_q, phase_d;
  logic             tick_q, tick_d;
  logic             pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic             ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic             cut_a, cut_b, serve_a, serve_b;

  // Prescaler: held at zero during hold so no tick can escape a maintenance freeze.
  always_comb begin
    tick_ev = !hold && (pre_q == PRE_W'(TICKS - 1));
    if (hold || tick_ev) pre_d = '0;
    else                 pre_d = pre_q + PRE_W'(1);
  end

  // Phase timer: cut an active green once its minimum has elapsed, else step with wrap.
  always_comb begin
    cut_a  = pend_a_q && (phase_q == PH_A_GREEN) && (time_q >= 7'(MIN_G_T - 1));
    cut_b  = pend_b_q && (phase_q == PH_B_GREEN) && (time_q >= 7'(HALF + MIN_G_T - 1));
    time_d = time_q;
    if (tick_ev) begin
      if (cut_a)                            time_d = 7'(G_T);
      else if (cut_b)                       time_d = 7'(HALF + G_T);
      else if (time_q == 7'(2 * HALF - 1))  time_d = '0;
      else                                  time_d = time_q + 7'd1;
    end
    phase_d = band(int'(time_d), G_T, Y_T, R_T);
    tick_d  = tick_ev;
  end

  // Pedestrian requests: served on the tick that enters the other road's green.
  always_comb begin
    serve_a  = tick_ev && (time_d == 7'(HALF));
    serve_b  = tick_ev && (time_d == 7'd0);
    pend_a_d = serve_a ? 1'b0 : (pend_a_q | ped_req_a);
    pend_b_d = serve_b ? 1'b0 : (pend_b_q | ped_req_b);
    ack_a_d  = serve_a;
    ack_b_d  = serve_b;
  end

  // State registers; reset drops back to the start of A green and forgets requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      time_q   <= '0;
      phase_q  <= PH_A_GREEN;
      tick_q   <= 1'b0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      time_q   <= time_d;
      phase_q  <= phase_d;
      tick_q   <= tick_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
    end
  end

  pwm_gen #(.PWM_DIV(PWM_DIV)) u_pwm (
    .clk      (clk),
    .rst_n    (rst_n),
    .pwm_12p5 (pwm_12p5),
    .pwm_25   (pwm_25)
  );

  assign phase_time = time_q;
  assign phase      = phase_q;
  assign tick       = tick_q;
  assign ped_ack_a  = ack_a_q;
  assign ped_ack_b  = ack_b_q;

endmodule
